// File: rtl/wb_shared_port_arbiter_pkg.sv
// Shared types and default constants for the two-master Wishbone shared-port arbiter.
package wb_shared_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_TIMEOUT  = 255;
  localparam int unsigned DEF_TW       = 8;
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the master that did not win last time is granted.
module wb_rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0] && (!req_i[1] || last_grant_i)) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/wb_shared_port_arbiter.sv
// Two-master, one-slave Wishbone arbiter: single transfer per grant, registered slave drive,
// round-robin grant and a bus-timeout watchdog that aborts a stuck transfer.
module wb_shared_port_arbiter
  import wb_shared_port_arbiter_pkg::*;
#(
  parameter int unsigned     AW       = 32,
  parameter int unsigned     DW       = 32,
  parameter int unsigned     TIMEOUT  = DEF_TIMEOUT,
  parameter int unsigned     TW       = DEF_TW,
  parameter logic [DW-1:0]   ERR_DATA = DW'(DEF_ERR_DATA)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  input  logic [AW-1:0]     m0_adr_i,
  input  logic [DW-1:0]     m0_dat_i,
  output logic [DW-1:0]     m0_dat_o,
  output logic              m0_ack_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW-1:0]     m1_dat_i,
  output logic [DW-1:0]     m1_dat_o,
  output logic              m1_ack_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  output logic              timeout_o,
  output logic              owner_o
);

  arb_state_e        state_q, state_d;
  logic [1:0]        m_req, m_cyc, gnt, m_ack;
  logic              gsel;
  logic [AW-1:0]     m_adr [2];
  logic [DW-1:0]     m_wdat [2];
  logic [DW-1:0]     m_rdat [2];
  logic [DW/8-1:0]   m_sel [2];
  logic              m_we [2];

  logic              owner_q, last_grant_q, we_q, timeout_q;
  logic [AW-1:0]     adr_q;
  logic [DW-1:0]     wdat_q;
  logic [DW/8-1:0]   sel_q;
  logic [TW-1:0]     cnt_q, cnt_inc;
  logic              busy, resp, owner_live, cnt_hit, xfer_done, abort;

  assign m_req     = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
  assign m_cyc     = {m1_cyc_i, m0_cyc_i};
  assign m_adr[0]  = m0_adr_i;
  assign m_adr[1]  = m1_adr_i;
  assign m_wdat[0] = m0_dat_i;
  assign m_wdat[1] = m1_dat_i;
  assign m_sel[0]  = m0_sel_i;
  assign m_sel[1]  = m1_sel_i;
  assign m_we[0]   = m0_we_i;
  assign m_we[1]   = m1_we_i;

  wb_rr_arbiter2 u_rr (
    .req_i        (m_req),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  assign gsel       = gnt[1];
  assign owner_live = m_cyc[owner_q];
  // Watchdog saturates rather than wrapping; the incremented value is what gets compared.
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + TW'(1);
  assign cnt_hit    = (cnt_inc == TW'(TIMEOUT));
  assign xfer_done  = busy && owner_live && (s_ack_i || cnt_hit);
  assign abort      = busy && owner_live && !s_ack_i && cnt_hit;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (|gnt) state_d = BUSY;
      BUSY: begin
        if (!owner_live) begin
          state_d = IDLE;
        end else if (s_ack_i || cnt_hit) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == BUSY);
    resp    = (state_q == RESP);
    s_cyc_o = busy;
    s_stb_o = busy;
    s_we_o  = busy & we_q;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      adr_q        <= '0;
      wdat_q       <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      timeout_q <= abort;
      if (state_q == IDLE && |gnt) begin
        owner_q <= gsel;
        adr_q   <= m_adr[gsel];
        wdat_q  <= m_wdat[gsel];
        sel_q   <= m_sel[gsel];
        we_q    <= m_we[gsel];
        cnt_q   <= '0;
      end
      if (busy) cnt_q <= cnt_inc;
      if (resp) last_grant_q <= owner_q;
    end
  end

  // Each master keeps its own read-data register so a response to the other master never disturbs it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    logic [DW-1:0] rdat_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        rdat_q <= '0;
      end else if (xfer_done && owner_q == 1'(gi)) begin
        rdat_q <= abort ? ERR_DATA : s_dat_i;
      end
    end

    assign m_rdat[gi] = rdat_q;
    assign m_ack[gi]  = resp && (owner_q == 1'(gi));
  end

  assign m0_dat_o  = m_rdat[0];
  assign m1_dat_o  = m_rdat[1];
  assign m0_ack_o  = m_ack[0];
  assign m1_ack_o  = m_ack[1];
  assign s_adr_o   = adr_q;
  assign s_dat_o   = wdat_q;
  assign s_sel_o   = sel_q;
  assign timeout_o = timeout_q;
  assign owner_o   = owner_q;

endmodule
